// File: rtl/phase_scheduler_if.sv
// Bundles the requester handshake, detector launch/return and result signals
// of phase_scheduler. The slave modport is the scheduler; master is its environment.
interface phase_scheduler_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int SIZE_DATA    = 16,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) ();
    logic                              sched_enable;
    logic [NUM_CHANNELS-1:0]           req_valid;
    logic [NUM_CHANNELS-1:0]           req_ready;
    logic [NUM_CHANNELS*SIZE_DATA-1:0] req_i;
    logic [NUM_CHANNELS*SIZE_DATA-1:0] req_q;
    logic [SIZE_DATA-1:0]              phase_i;
    logic [SIZE_DATA-1:0]              phase_q;
    logic                              phase_enable;
    logic [SIZE_DATA-1:0]              phase_result;
    logic                              result_valid;
    logic [CH_W-1:0]                   result_channel;
    logic [SIZE_DATA-1:0]              result_data;
    logic                              result_zero;
    logic                              busy;

    modport slave (
        input  sched_enable, req_valid, req_i, req_q, phase_result,
        output req_ready, phase_i, phase_q, phase_enable,
               result_valid, result_channel, result_data, result_zero, busy
    );

    modport master (
        output sched_enable, req_valid, req_i, req_q, phase_result,
        input  req_ready, phase_i, phase_q, phase_enable,
               result_valid, result_channel, result_data, result_zero, busy
    );
endinterface

// File: rtl/phase_scheduler.sv
// Round-robin sharing of one phase detector among NUM_CHANNELS I/Q requesters,
// with a channel tag pipeline matched to the detector latency.
// Optional zero-input guard: define PHASE_SCHED_ZERO_GUARD_EN.
module phase_scheduler #(
    parameter int NUM_CHANNELS  = 4,
    parameter int SIZE_DATA     = 16,
    parameter int PHASE_LATENCY = 20,
    parameter int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    phase_scheduler_if.slave  bus
);

    logic [CH_W-1:0]          ptr_q, ptr_d;
    logic                     found_s, hit_s, xfer_s, zero_s;
    logic [CH_W-1:0]          grant_s;
    int unsigned              idx_s;
    logic [SIZE_DATA-1:0]     sel_i_s, sel_q_s, launch_i_s, launch_q_s;

    logic [SIZE_DATA-1:0]     phase_i_q, phase_q_q;
    logic                     phase_en_q;
    logic [PHASE_LATENCY-1:0] tag_valid_q;
    logic [CH_W-1:0]          tag_ch_q   [PHASE_LATENCY];
    logic                     tag_zero_q [PHASE_LATENCY];
    logic                     result_valid_q, result_zero_q;
    logic [CH_W-1:0]          result_channel_q;
    logic [SIZE_DATA-1:0]     result_data_q;

    // Arbiter: first valid channel at or after ptr, modulo NUM_CHANNELS.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        idx_s   = 32'd0;
        hit_s   = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            idx_s   = 32'(ptr_q) + i;
            idx_s   = (idx_s >= NUM_CHANNELS) ? (idx_s - NUM_CHANNELS) : idx_s;
            hit_s   = !found_s && bus.req_valid[CH_W'(idx_s)];
            grant_s = hit_s ? CH_W'(idx_s) : grant_s;
            found_s = found_s | hit_s;
        end
    end

    assign xfer_s        = found_s & bus.sched_enable & ~reset;
    assign bus.req_ready = xfer_s ? (NUM_CHANNELS'(1) << grant_s) : '0;

    // Operand selection, next pointer and optional zero-divisor substitution.
    always_comb begin
        sel_i_s = bus.req_i[grant_s*SIZE_DATA +: SIZE_DATA];
        sel_q_s = bus.req_q[grant_s*SIZE_DATA +: SIZE_DATA];
        ptr_d   = ptr_q;
        if (xfer_s) begin
            ptr_d = (grant_s == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_s + CH_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
`ifdef PHASE_SCHED_ZERO_GUARD_EN
        zero_s     = (sel_i_s == '0) && (sel_q_s == '0);
        launch_i_s = zero_s ? SIZE_DATA'(1) : sel_i_s;
        launch_q_s = zero_s ? '0 : sel_q_s;
`else
        zero_s     = 1'b0;
        launch_i_s = sel_i_s;
        launch_q_s = sel_q_s;
`endif
    end

    // Launch register, tag pipeline and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q            <= '0;
            phase_i_q        <= '0;
            phase_q_q        <= '0;
            phase_en_q       <= 1'b0;
            tag_valid_q      <= '0;
            for (int k = 0; k < PHASE_LATENCY; k++) begin
                tag_ch_q[k]   <= '0;
                tag_zero_q[k] <= 1'b0;
            end
            result_valid_q   <= 1'b0;
            result_channel_q <= '0;
            result_data_q    <= '0;
            result_zero_q    <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            phase_en_q <= xfer_s;
            if (xfer_s) begin
                phase_i_q <= launch_i_s;
                phase_q_q <= launch_q_s;
            end
            // Stage 0 runs alongside phase_enable so the result lands PHASE_LATENCY after launch.
            tag_valid_q[0] <= xfer_s;
            tag_ch_q[0]    <= grant_s;
            tag_zero_q[0]  <= xfer_s & zero_s;
            for (int k = 1; k < PHASE_LATENCY; k++) begin
                tag_valid_q[k] <= tag_valid_q[k-1];
                tag_ch_q[k]    <= tag_ch_q[k-1];
                tag_zero_q[k]  <= tag_zero_q[k-1];
            end
            result_valid_q <= tag_valid_q[PHASE_LATENCY-1];
            result_zero_q  <= tag_valid_q[PHASE_LATENCY-1] & tag_zero_q[PHASE_LATENCY-1];
            if (tag_valid_q[PHASE_LATENCY-1]) begin
                result_channel_q <= tag_ch_q[PHASE_LATENCY-1];
                result_data_q    <= tag_zero_q[PHASE_LATENCY-1] ? '0 : bus.phase_result;
            end
        end
    end

    assign bus.phase_i        = phase_i_q;
    assign bus.phase_q        = phase_q_q;
    assign bus.phase_enable   = phase_en_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result_channel = result_channel_q;
    assign bus.result_data    = result_data_q;
    assign bus.result_zero    = result_zero_q;
    assign bus.busy           = phase_en_q | (|tag_valid_q) | result_valid_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed self-checking bench for phase_scheduler (4 channels, 16-bit, latency 20).
// The detector is stood in for by a cycle-count ramp on phase_result.
module tb_phase_scheduler;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L  = 20;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    phase_scheduler_if #(.NUM_CHANNELS(N), .SIZE_DATA(W)) bus ();

    phase_scheduler #(.NUM_CHANNELS(N), .SIZE_DATA(W), .PHASE_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.phase_result = 16'h1000 + cyc[15:0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_all_data();
        for (int k = 0; k < N; k++) begin
            bus.req_i[k*W +: W] = 16'(k*10 + 1);
            bus.req_q[k*W +: W] = 16'(k*10 + 2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 4'hF;
        tick();
        tick();
        total_cnt++;
        if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({bus.phase_enable, bus.result_valid, bus.busy, bus.result_zero} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus.phase_enable, bus.result_valid, bus.busy, bus.result_zero});
        else pass_cnt++;
        total_cnt++;
        if ({bus.phase_i, bus.phase_q, bus.result_data} !== 48'd0 || bus.result_channel !== 2'd0)
            $display("FAIL reset_data got=%h/%h/%h ch=%0d exp=0",
                     bus.phase_i, bus.phase_q, bus.result_data, bus.result_channel);
        else pass_cnt++;
        bus.req_valid = 4'h0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        logic [15:0] exp_d;
        bus.req_i[2*W +: W] = 16'd100;
        bus.req_q[2*W +: W] = 16'd50;
        bus.req_valid = 4'b0100;
        #1;
        n = cyc;
        total_cnt++;
        if (bus.req_ready !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", bus.req_ready);
        else pass_cnt++;
        tick();
        bus.req_valid = 4'b0000;
        total_cnt++;
        if (bus.phase_i !== 16'd100 || bus.phase_q !== 16'd50 || bus.phase_enable !== 1'b1)
            $display("FAIL single_launch got=%0d/%0d en=%b exp=100/50 en=1",
                     bus.phase_i, bus.phase_q, bus.phase_enable);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.phase_enable !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL single_pulse got en=%b busy=%b exp en=0 busy=1", bus.phase_enable, bus.busy);
        else pass_cnt++;
        while (cyc < n + 20) tick();
        total_cnt++;
        if (bus.result_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", bus.result_valid);
        else pass_cnt++;
        tick();
        exp_d = 16'h1000 + 16'(n + 20);
        total_cnt++;
        if (bus.result_valid !== 1'b1 || bus.result_channel !== 2'd2 ||
            bus.result_data !== exp_d || bus.result_zero !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL single_result got v=%b ch=%0d d=%h z=%b busy=%b exp v=1 ch=2 d=%h z=0 busy=1",
                     bus.result_valid, bus.result_channel, bus.result_data, bus.result_zero, bus.busy, exp_d);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL single_done got v=%b busy=%b exp 0/0", bus.result_valid, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        int n0;
        int errs;
        logic [3:0]  exp_r;
        logic [15:0] exp_d;
        do_reset();
        set_all_data();
        bus.req_valid = 4'hF;
        #1;
        n0 = cyc;
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            exp_r = 4'(1) << (i % 4);
            if (bus.req_ready !== exp_r) begin
                $display("FAIL fair_grant i=%0d got=%b exp=%b", i, bus.req_ready, exp_r);
                errs++;
            end
            tick();
            if (bus.phase_i !== 16'((i % 4)*10 + 1) || bus.phase_enable !== 1'b1) begin
                $display("FAIL fair_launch i=%0d got=%0d en=%b exp=%0d en=1",
                         i, bus.phase_i, bus.phase_enable, (i % 4)*10 + 1);
                errs++;
            end
        end
        bus.req_valid = 4'h0;
        total_cnt++;
        if (errs == 0) pass_cnt++;
        while (cyc < n0 + 21) tick();
        errs = 0;
        for (int i = 0; i < 12; i++) begin
            exp_d = 16'h1000 + 16'(n0 + 20 + i);
            if (bus.result_valid !== 1'b1 || bus.result_channel !== 2'(i % 4) || bus.result_data !== exp_d) begin
                $display("FAIL fair_result i=%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                         i, bus.result_valid, bus.result_channel, bus.result_data, i % 4, exp_d);
                errs++;
            end
            tick();
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        total_cnt++;
        if (bus.result_valid !== 1'b0) $display("FAIL fair_tail got=%b exp=0", bus.result_valid);
        else pass_cnt++;
    endtask

    task automatic test_gating();
        int n;
        int errs;
        bus.sched_enable = 1'b0;
        bus.req_valid = 4'b0010;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.req_ready !== 4'b0000 || bus.phase_enable !== 1'b0) begin
                $display("FAIL gate_hold i=%0d got rdy=%b en=%b exp 0000/0", i, bus.req_ready, bus.phase_enable);
                errs++;
            end
            tick();
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        bus.sched_enable = 1'b1;
        #1;
        n = cyc;
        total_cnt++;
        if (bus.req_ready !== 4'b0010) $display("FAIL gate_release got=%b exp=0010", bus.req_ready);
        else pass_cnt++;
        tick();
        bus.req_valid = 4'b0000;
        while (cyc < n + 21) tick();
        total_cnt++;
        if (bus.result_valid !== 1'b1 || bus.result_channel !== 2'd1)
            $display("FAIL gate_result got v=%b ch=%0d exp v=1 ch=1", bus.result_valid, bus.result_channel);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_midflight_reset();
        int errs;
        bus.req_valid = 4'hF;
        tick();
        tick();
        tick();
        bus.req_valid = 4'h0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.phase_enable !== 1'b0)
            $display("FAIL mid_clear got busy=%b v=%b en=%b exp 0/0/0", bus.busy, bus.result_valid, bus.phase_enable);
        else pass_cnt++;
        errs = 0;
        for (int i = 0; i < 21; i++) begin
            if (bus.result_valid !== 1'b0) begin
                $display("FAIL mid_quiet i=%0d got=%b exp=0", i, bus.result_valid);
                errs++;
            end
            tick();
        end
        total_cnt++;
        if (errs == 0) pass_cnt++;
        bus.req_valid = 4'hF;
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL mid_ptr got=%b exp=0001", bus.req_ready);
        else pass_cnt++;
        bus.req_valid = 4'h0;
        tick();
    endtask

    task automatic test_zero_guard();
        int n;
        logic [15:0] exp_pi;
        logic [15:0] exp_d;
        logic        exp_z;
`ifdef PHASE_SCHED_ZERO_GUARD_EN
        exp_pi = 16'd1;
        exp_z  = 1'b1;
`else
        exp_pi = 16'd0;
        exp_z  = 1'b0;
`endif
        bus.req_i[0 +: W] = 16'd0;
        bus.req_q[0 +: W] = 16'd0;
        bus.req_valid = 4'b0001;
        #1;
        n = cyc;
        tick();
        bus.req_valid = 4'b0000;
        total_cnt++;
        if (bus.phase_i !== exp_pi || bus.phase_q !== 16'd0 || bus.phase_enable !== 1'b1)
            $display("FAIL zero_launch got=%0d/%0d en=%b exp=%0d/0 en=1",
                     bus.phase_i, bus.phase_q, bus.phase_enable, exp_pi);
        else pass_cnt++;
        exp_d = exp_z ? 16'd0 : (16'h1000 + 16'(n + 20));
        while (cyc < n + 21) tick();
        total_cnt++;
        if (bus.result_valid !== 1'b1 || bus.result_channel !== 2'd0 ||
            bus.result_data !== exp_d || bus.result_zero !== exp_z)
            $display("FAIL zero_result got v=%b ch=%0d d=%h z=%b exp v=1 ch=0 d=%h z=%b",
                     bus.result_valid, bus.result_channel, bus.result_data, bus.result_zero, exp_d, exp_z);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_pointer_wrap();
        bus.req_valid = 4'b1000;
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b1000) $display("FAIL wrap_first got=%b exp=1000", bus.req_ready);
        else pass_cnt++;
        tick();
        bus.req_valid = 4'b1001;
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL wrap_ch0 got=%b exp=0001", bus.req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.req_ready !== 4'b1000) $display("FAIL wrap_ch3 got=%b exp=1000", bus.req_ready);
        else pass_cnt++;
        tick();
        bus.req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.sched_enable = 1'b1;
        bus.req_valid = '0;
        bus.req_i = '0;
        bus.req_q = '0;
        test_reset();
        test_single();
        test_fairness();
        test_gating();
        test_midflight_reset();
        test_zero_guard();
        test_pointer_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
